sevseg_bcd_encoder: RTL and testbench
=====================================

// Module: sevseg_bcd_encoder
// PURPOSE
//   Upstream feeder for the 4-digit seven-segment scan driver. Accepts a binary
//   value over a valid/ready handshake and converts it to BCD with an iterative
//   double-dabble FSM. It then encodes the digits into active-low segment bytes
//   on displaychar1..4 (1 = rightmost/LSD) and holds them stable until the next
//   conversion completes.
// PARAMETERS
//   WIDTH          14  bit width of in_value; legal range 4..14
//   BLANK_LEADING  1   1 = blank leading zeros of digits 4..2; 0 = show all digits
// PORTS
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   in_valid      in   1      in_value/dp_mask valid
//   in_ready      out  1      block idle, can accept (combinational = state==IDLE)
//   in_value      in   WIDTH  unsigned binary value to display
//   dp_mask       in   4      decimal point enables; bit i -> displaychar(i+1)
//   busy          out  1      conversion in progress (= !in_ready)
//   done          out  1      one-cycle pulse when displaychar1..4 update
//   displaychar1  out  8      LSD segment byte {dp,g,f,e,d,c,b,a}, active-low
//   displaychar2  out  8      digit 2 segment byte
//   displaychar3  out  8      digit 3 segment byte
//   displaychar4  out  8      MSD segment byte
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, displaychar1..4=8'hFF (all off), done=0,
//     internal shift/BCD/count regs cleared; in_ready=1 once in IDLE.
//   - FSM: IDLE -> SHIFT -> ENCODE -> IDLE.
//   - IDLE: transfer on clk edge with in_valid & in_ready. Capture in_value and
//     dp_mask; ovf = (in_value > 9999); clear 16-bit BCD reg; count=WIDTH; go SHIFT.
//   - SHIFT: each cycle add 3 to every BCD nibble >= 5, then shift {bcd,bin} left 1.
//     Decrement count; at count==1 the last shift occurs and the FSM goes to ENCODE.
//     SHIFT lasts exactly WIDTH cycles.
//   - ENCODE: one cycle. Register all four displaychars, assert done for this
//     cycle only, go IDLE.
//   - Latency: transfer at edge N; outputs and done change at edge N+WIDTH+1.
//     Default WIDTH gives 15 cycles. Next transfer is possible at edge N+WIDTH+2.
//   - Segment table, seg[6:0] active-low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
//     8=80 9=90 (bit7=1). Blank=FF. Dash=BF.
//   - DP: bit7 of digit i is cleared when dp_mask[i]=1, including blanked digits.
//   - Blanking (BLANK_LEADING=1): digit k (k=4..2) is blank if it and all higher
//     digits are 0. Digit 1 is never blanked, so value 0 shows "0".
//   - Overflow: if ovf, all four chars are BF and dp_mask is ignored. Same latency.
//   - in_valid while busy: ignored; no capture, no queuing. in_value may change freely.
//   - displaychar1..4 hold previous values for the whole conversion (no flicker)
//     and change only in ENCODE.
//   - rst_n asserted mid-conversion: immediate abort to reset values; the partial
//     result is never output.
//   - All outputs except in_ready/busy are registered.
// TESTING
//   1 rst_n=0 then release -> displaychar1..4=FF, in_ready=1, done=0.
//   2 in_value=1234, dp_mask=0 -> done 15 cycles after transfer.
//     char1..4=99,B0,A4,F9; done high exactly 1 cycle.
//   3 in_value=7, BLANK_LEADING=1 -> char1=F8, char2..4=FF.
//     in_value=0 -> char1=C0, others FF.
//   4 in_value=10000, dp_mask=F -> all chars BF.
//     in_value=9999 -> all chars 90.
//   5 in_value=5, dp_mask=4'b0011 -> char1=12, char2=7F, char3..4=FF.
//     in_valid held high with in_value=42 during busy -> no second capture.
//     char1..4 unchanged until done.
//   6 Convert 1234, then transfer 56 and pull rst_n low at cycle 5 of SHIFT.
//     -> chars=FF immediately, in_ready=1 after release, no done pulse.

Source files
------------

// File: rtl/sevseg_bcd_encoder_if.sv
// Handshake and display bus between a value producer and the BCD/segment encoder.
// The master drives values in; the slave returns status and the four segment bytes.
interface sevseg_bcd_encoder_if #(
   parameter int WIDTH = 14
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_value;
   logic [3:0]       dp_mask;
   logic             busy;
   logic             done;
   logic [7:0]       displaychar1;
   logic [7:0]       displaychar2;
   logic [7:0]       displaychar3;
   logic [7:0]       displaychar4;

   modport master (
      output in_valid,
      output in_value,
      output dp_mask,
      input  in_ready,
      input  busy,
      input  done,
      input  displaychar1,
      input  displaychar2,
      input  displaychar3,
      input  displaychar4
   );

   modport slave (
      input  in_valid,
      input  in_value,
      input  dp_mask,
      output in_ready,
      output busy,
      output done,
      output displaychar1,
      output displaychar2,
      output displaychar3,
      output displaychar4
   );
endinterface

// File: rtl/sevseg_bcd_encoder.sv
// Binary to 4-digit BCD via iterative double-dabble, then active-low segment encoding
// with leading-zero blanking, decimal points and an overflow dash pattern.
module sevseg_bcd_encoder #(
   parameter int WIDTH         = 14,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sevseg_bcd_encoder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      ENCODE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [3:0]       count_q, count_d;
   logic [3:0]       dp_q, dp_d;
   logic             ovf_q, ovf_d;
   logic [3:0][7:0]  char_q, char_d;
   logic             done_q, done_d;

   logic [15:0]      bcd_adj;
   logic [3:0][7:0]  enc;
   logic [3:0]       lead_zero;

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      logic [6:0] s;
      case (digit)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Per-digit add-3 correction and segment encoding of the finished BCD value.
   // lead_zero[k] is true when digit k and every digit above it are zero.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         logic [3:0] nib;
         logic       blank;

         assign nib = bcd_q[4*gi +: 4];
         assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;

         if (gi == 3) begin : g_top
            assign lead_zero[gi] = (nib == 4'd0);
         end else begin : g_low
            assign lead_zero[gi] = lead_zero[gi+1] && (nib == 4'd0);
         end

         assign blank   = BLANK_LEADING && (gi != 0) && lead_zero[gi];
         assign enc[gi] = ovf_q ? 8'hBF : {~dp_q[gi], (blank ? 7'h7F : seg7(nib))};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      count_d = count_q;
      dp_d    = dp_q;
      ovf_d   = ovf_q;
      char_d  = char_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               bin_d   = bus.in_value;
               dp_d    = bus.dp_mask;
               ovf_d   = 32'(bus.in_value) > 32'd9999;
               bcd_d   = '0;
               count_d = 4'(WIDTH);
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            // A carry out of the top nibble can only come from a value above 9999.
            ovf_d   = ovf_q | bcd_adj[15];
            bcd_d   = {bcd_adj[14:0], bin_q[WIDTH-1]};
            bin_d   = {bin_q[WIDTH-2:0], 1'b0};
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
               state_d = ENCODE;
            end
         end

         ENCODE: begin
            char_d  = enc;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         count_q <= '0;
         dp_q    <= '0;
         ovf_q   <= 1'b0;
         char_q  <= {4{8'hFF}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         count_q <= count_d;
         dp_q    <= dp_d;
         ovf_q   <= ovf_d;
         char_q  <= char_d;
         done_q  <= done_d;
      end
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = done_q;
   assign bus.displaychar1 = char_q[0];
   assign bus.displaychar2 = char_q[1];
   assign bus.displaychar3 = char_q[2];
   assign bus.displaychar4 = char_q[3];

endmodule

// File: tb/tb_sevseg_bcd_encoder.sv
// Self-checking bench: directed vector table, busy/abort sequences, and random values
// checked against an arithmetic (divide/modulo) display model.
module tb_sevseg_bcd_encoder;
   localparam int WIDTH = 14;
   localparam int LAT   = WIDTH + 1;
   localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct {
      int          value;
      logic [3:0]  mask;
      logic [31:0] exp;   // {char4, char3, char2, char1}
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   sevseg_bcd_encoder_if #(.WIDTH(WIDTH)) bus ();

   sevseg_bcd_encoder #(
      .WIDTH         (WIDTH),
      .BLANK_LEADING (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] chars();
      return {bus.displaychar4, bus.displaychar3, bus.displaychar2, bus.displaychar1};
   endfunction

   // Digit k shows (value / 10^k) % 10; digits above the first are blank when value < 10^k.
   function automatic logic [31:0] model(input int value, input logic [3:0] mask);
      logic [31:0] r;
      logic [7:0]  c;
      int          p;
      r = '0;
      p = 1;
      if (value > 9999) return 32'hBFBFBFBF;
      for (int k = 0; k < 4; k++) begin
         if (k > 0 && value < p) c = 8'hFF;
         else                    c = SEG_TAB[(value / p) % 10];
         if (mask[k]) c[7] = 1'b0;
         r[8*k +: 8] = c;
         p = p * 10;
      end
      return r;
   endfunction

   task automatic xfer(input string name, input int value, input logic [3:0] mask,
                       input logic [31:0] exp, input bit hold_busy);
      logic [31:0] prev;
      int          lat;
      int          waited;
      bit          flicker;
      bit          extra_done;

      waited = 0;
      while (!bus.in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      check($sformatf("%s ready", name), 32'(bus.in_ready), 32'd1);
      prev = chars();

      @(negedge clk);
      bus.in_value = WIDTH'(value);
      bus.dp_mask  = mask;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      if (hold_busy) bus.in_value = WIDTH'(42);
      else           bus.in_valid = 1'b0;
      check($sformatf("%s busy", name), 32'(bus.busy), 32'd1);

      lat     = 0;
      flicker = 1'b0;
      while (!bus.done && lat < 40) begin
         if (chars() !== prev) flicker = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      bus.in_valid = 1'b0;
      check($sformatf("%s latency", name), 32'(lat), 32'(LAT));
      check($sformatf("%s hold", name), 32'(flicker), 32'd0);
      check($sformatf("%s chars", name), chars(), exp);

      @(posedge clk); #1;
      check($sformatf("%s done_pulse", name), 32'(bus.done), 32'd0);
      check($sformatf("%s idle", name), 32'(bus.in_ready), 32'd1);

      if (hold_busy) begin
         extra_done = 1'b0;
         repeat (20) begin
            @(posedge clk); #1;
            if (bus.done || !bus.in_ready) extra_done = 1'b1;
         end
         check($sformatf("%s no_recapture", name), 32'(extra_done), 32'd0);
         check($sformatf("%s kept", name), chars(), exp);
      end
      $display("xfer %s value=%0d mask=%b latency=%0d chars=%h expected=%h",
               name, value, mask, lat, chars(), exp);
   endtask

   initial begin
      vec_t vec [12];
      bit   saw_done;
      int   value;

      vec[0]  = '{1234,  4'h0, 32'hF9A4B099};
      vec[1]  = '{7,     4'h0, 32'hFFFFFFF8};
      vec[2]  = '{0,     4'h0, 32'hFFFFFFC0};
      vec[3]  = '{10000, 4'hF, 32'hBFBFBFBF};
      vec[4]  = '{9999,  4'h0, 32'h90909090};
      vec[5]  = '{5,     4'h3, 32'hFFFF7F12};
      vec[6]  = '{100,   4'h0, 32'hFFF9C0C0};
      vec[7]  = '{1000,  4'h8, 32'h79C0C0C0};
      vec[8]  = '{16383, 4'h5, 32'hBFBFBFBF};
      vec[9]  = '{10,    4'h0, 32'hFFFFF9C0};
      vec[10] = '{2,     4'h4, 32'hFF7FFFA4};
      vec[11] = '{8060,  4'h0, 32'h80C082C0};

      bus.in_valid = 1'b0;
      bus.in_value = '0;
      bus.dp_mask  = '0;
      rst_n        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset chars", chars(), 32'hFFFFFFFF);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset ready", 32'(bus.in_ready), 32'd1);
      check("reset busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         xfer($sformatf("vec%0d", i), vec[i].value, vec[i].mask, vec[i].exp, 1'b0);
      end

      xfer("busy_hold", 5, 4'b0011, 32'hFFFF7F12, 1'b1);

      // Abort a conversion of 56 partway through SHIFT.
      xfer("pre_abort", 1234, 4'h0, 32'hF9A4B099, 1'b0);
      @(negedge clk);
      bus.in_value = WIDTH'(56);
      bus.dp_mask  = 4'h0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort chars", chars(), 32'hFFFFFFFF);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.done) saw_done = 1'b1;
      end
      check("abort no_done", 32'(saw_done), 32'd0);
      check("abort still_blank", chars(), 32'hFFFFFFFF);
      $display("xfer abort value=56 chars=%h", chars());

      for (int i = 0; i < 40; i++) begin
         logic [3:0] m;
         if ($urandom_range(0, 3) == 0) value = int'($urandom_range(10000, 16383));
         else                           value = int'($urandom_range(0, 9999));
         m = 4'($urandom);
         xfer($sformatf("rnd%0d", i), value, m, model(value, m), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
